ym_serial_capture: RTL and testbench
====================================

# ym_serial_capture

Deserializes the 16-bit two-channel serial audio stream produced by the YM3012-to-uPD6376 converter (DATA plus LRCK, MSB first) back into parallel stereo frames. It buffers the frames in a small FIFO that the 68040 bus glue drains. It sits directly downstream of the converter and runs on the converter's clock, so both serial inputs are already synchronous.

## Interface
- `DEPTH`, default 16: FIFO depth in stereo frames; a power of two, at least 2.
- `LW`, default 5: width of `o_LEVEL`; equals log2(`DEPTH`)+1.
- `i_CLOCK` in, 1: the same clock as the converter. One clock; all logic is on its rising edge.
- `i_RESET` in, 1: synchronous, active-high reset.
- `i_DATA` in, 1: serial sample bit (converter data output). The converter updates it on the falling edge.
- `i_LRCK` in, 1: channel select. 1 = channel 1 (left), 0 = channel 2 (right).
- `i_ENABLE` in, 1: capture enable. FIFO contents are unaffected by this input.
- `i_RD` in, 1: pop strobe, one frame per cycle. Ignored when the FIFO is empty.
- `i_CLR_FLAGS` in, 1: clears `o_OVF` and `o_SHORT`.
- `o_RDATA` out, 32: head frame, {left[15:0], right[15:0]}. Valid while `o_EMPTY`=0 (first-word fall-through).
- `o_EMPTY` out, 1: FIFO empty.
- `o_FULL` out, 1: FIFO holds `DEPTH` frames.
- `o_LEVEL` out, `LW`: number of frames held, 0..`DEPTH`.
- `o_OVF` out, 1: sticky; a completed frame was dropped because the FIFO was full.
- `o_SHORT` out, 1: sticky; an LRCK edge arrived before 16 bits of the current word were captured.

## Operation
- **Edge detect.** Register `r_PrevLRCK` samples `i_LRCK` every cycle and resets to 1, matching the converter's LRCK reset level. An LRCK edge is a cycle where `i_LRCK` differs from `r_PrevLRCK`.
- **Bit capture.** The converter places a word's MSB on `i_DATA` in the same cycle LRCK toggles.
  - On an edge cycle, the block samples `i_DATA` as bit 15, sets the bit counter to 1, and latches the channel as the new `i_LRCK` value.
  - On each following cycle with counter 1..15, it shifts `i_DATA` in as the next lower bit and increments the counter.
  - At counter 16 the word is complete and the counter holds at 16. Further bits are ignored until the next edge; the converter pads them with zeros.
- **Word states.** IDLE (counter 16 or never started), then SHIFT (counter 1..15), then DONE (word handed off; returns to IDLE).
- **Left word.** A completed channel-1 word goes into `r_Left` and sets `r_LeftValid`.
- **Right word and frame push.** When a channel-2 word completes with `r_LeftValid`=1, the frame {`r_Left`, right} is pushed and `r_LeftValid` clears.
  - If `r_LeftValid`=0, the right word is discarded. This is normal at start-up.
  - A new completed left word overwrites a held left word that has no right partner. No flag is raised.
- **Short word.** An LRCK edge while the counter is 1..15 discards the partial word and sets `o_SHORT`. The edge still starts the new word normally.
  - If the aborted word was channel 2, `r_LeftValid` also clears.
- **Enable.** With `i_ENABLE`=0:
  - the counter is forced to 16 and `r_LeftValid` clears;
  - no push occurs and no flag is set.
  - Edge detection keeps tracking, so after re-enable capture begins at the next LRCK edge.
- **FIFO.** Circular buffer of `DEPTH` × 32 bits with read and write pointers one bit wider than the address.
  - Push when full: the frame is dropped, `o_OVF` is set, and the pointers are unchanged, unless `i_RD` is asserted in the same cycle (see next item).
  - Push and pop in the same cycle: both happen and `o_LEVEL` is unchanged. This applies when full as well (pop first, so no overflow).
  - Pop when empty: ignored.
  - Pointers wrap modulo `DEPTH`.
- **Flags.** Sticky until `i_CLR_FLAGS`. If a set event and `i_CLR_FLAGS` occur in the same cycle, the set wins.
- **Reset.** `i_RESET` mid-word or mid-frame drops the partial word and the held left word, and empties the FIFO.

## Timing
- Reset values: `o_EMPTY`=1, `o_FULL`=0, `o_LEVEL`=0, `o_OVF`=0, `o_SHORT`=0, `o_RDATA`=0. Internally, counter=16, `r_PrevLRCK`=1, `r_LeftValid`=0.
- Bit 0 of a word is sampled 15 cycles after the edge cycle. The word completes at that same rising edge.
- Frame push takes effect at the rising edge where right bit 0 is sampled. After that edge, `o_EMPTY` goes low, `o_LEVEL` increments, and `o_RDATA` shows the frame if it is the head. Latency from the right-channel LRCK edge to `o_EMPTY` falling is 16 cycles.
- `i_RD` sampled high at edge N: `o_RDATA` shows the next entry after edge N, and `o_LEVEL` decrements after edge N.
- Minimum LRCK half-period for loss-free capture is 16 cycles. Shorter half-periods produce `o_SHORT`.

## Test plan
- **Single frame.** After reset, drive left=0x8000 then right=0x7FC0, each with 32 cycles per LRCK half. Required: `o_RDATA`=0x80007FC0, `o_LEVEL`=1, and `o_EMPTY` falls 16 cycles after the falling LRCK edge.
- **Start mid-stream.** Enable during a right half, then send L=0x0001, R=0xFFFF. Required: the first partial right word is discarded, and the FIFO holds exactly 0x0001FFFF.
- **Short word.** Toggle LRCK 8 cycles after the previous edge. Required: `o_SHORT`=1, no push, and the next full L/R pair pushes correctly. Then `i_CLR_FLAGS` pulsed clears `o_SHORT`.
- **Overflow.** Push `DEPTH`+1 frames (the frame index in both halves) with no reads. Required: `o_FULL`=1, `o_LEVEL`=16, `o_OVF`=1, and frames 0..15 read back in order. A push with a same-cycle `i_RD` while full does not set `o_OVF`.
- **Wrap-around.** Interleave pushes and pops across 40 frames. Required: data is in order, `o_LEVEL` is always correct, and `o_EMPTY` is reasserted after the last pop.
- **Reset mid-word.** Assert `i_RESET` on bit 7 of a left word with 3 frames queued. Required: all outputs return to reset values, and the next complete pair is the only FIFO entry.

Source files
------------

// File: rtl/ym_serial_capture.sv
// Serial-to-parallel capture of the converter's 16-bit L/R stream into a FWFT frame FIFO.
// word state | meaning:  IDLE = cnt 16 (complete/not started), SHIFT = cnt 1..15, DONE = cnt 15 with no edge (hand-off)
module ym_serial_capture #(
    parameter int DEPTH = 16,
    parameter int LW    = 5
) (
    input  logic          i_CLOCK,
    input  logic          i_RESET,
    input  logic          i_DATA,
    input  logic          i_LRCK,
    input  logic          i_ENABLE,
    input  logic          i_RD,
    input  logic          i_CLR_FLAGS,
    output logic [31:0]   o_RDATA,
    output logic          o_EMPTY,
    output logic          o_FULL,
    output logic [LW-1:0] o_LEVEL,
    output logic          o_OVF,
    output logic          o_SHORT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] CNT_LAST = 5'd15;

    logic          prev_lrck_q;
    logic [4:0]    cnt_q, cnt_d;
    logic [14:0]   shift_q, shift_d;
    logic          chan_q, chan_d;
    logic [15:0]   left_q, left_d;
    logic          left_valid_q, left_valid_d;
    logic          ovf_q, ovf_d;
    logic          short_q, short_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]   mem_q [DEPTH];

    logic          lrck_edge;
    logic          shifting;
    logic          word_done;
    logic [15:0]   word;
    logic          short_evt;
    logic          push_req;
    logic          fifo_empty;
    logic          fifo_full;
    logic          do_push;
    logic          do_pop;
    logic          ovf_evt;
    logic [AW:0]   level;

    assign lrck_edge = i_LRCK ^ prev_lrck_q;
    assign shifting  = (cnt_q != CNT_FULL);
    assign word      = {shift_q, i_DATA};
    assign word_done = i_ENABLE && !lrck_edge && (cnt_q == CNT_LAST);
    assign short_evt = i_ENABLE && lrck_edge && shifting;
    assign push_req  = word_done && !chan_q && left_valid_q;

    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        chan_d       = chan_q;
        left_d       = left_q;
        left_valid_d = left_valid_q;
        if (!i_ENABLE) begin
            cnt_d        = CNT_FULL;
            left_valid_d = 1'b0;
        end else if (lrck_edge) begin
            cnt_d   = 5'd1;
            shift_d = {14'd0, i_DATA};
            chan_d  = i_LRCK;
            // an aborted right word cannot pair with the held left word
            if (shifting && !chan_q) begin
                left_valid_d = 1'b0;
            end
        end else if (shifting) begin
            cnt_d   = cnt_q + 5'd1;
            shift_d = word[14:0];
            if (word_done) begin
                if (chan_q) begin
                    left_d       = word;
                    left_valid_d = 1'b1;
                end else begin
                    left_valid_d = 1'b0;
                end
            end
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level      = wr_ptr_q - rd_ptr_q;

    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_pop   = i_RD && !fifo_empty;
    assign do_push  = push_req && (!fifo_full || do_pop);
    assign ovf_evt  = push_req && fifo_full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        ovf_d    = ovf_evt   | (ovf_q   & ~i_CLR_FLAGS);
        short_d  = short_evt | (short_q & ~i_CLR_FLAGS);
    end

    always_ff @(posedge i_CLOCK) begin
        if (i_RESET) begin
            prev_lrck_q  <= 1'b1;
            cnt_q        <= CNT_FULL;
            shift_q      <= '0;
            chan_q       <= 1'b0;
            left_q       <= '0;
            left_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            short_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            prev_lrck_q  <= i_LRCK;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            chan_q       <= chan_d;
            left_q       <= left_d;
            left_valid_q <= left_valid_d;
            ovf_q        <= ovf_d;
            short_q      <= short_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_CLOCK) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {left_q, word};
        end
    end

    assign o_RDATA = fifo_empty ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]];
    assign o_EMPTY = fifo_empty;
    assign o_FULL  = fifo_full;
    assign o_LEVEL = LW'(level);
    assign o_OVF   = ovf_q;
    assign o_SHORT = short_q;

endmodule

// File: tb/tb_ym_serial_capture.sv
// Directed bench for ym_serial_capture: stream frames in on the falling edge, check FIFO contents and flags.
module tb_ym_serial_capture;

    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          i_RESET = 1'b1;
    logic          i_DATA = 1'b0;
    logic          i_LRCK = 1'b1;
    logic          i_ENABLE = 1'b0;
    logic          i_RD = 1'b0;
    logic          i_CLR_FLAGS = 1'b0;
    logic [31:0]   o_RDATA;
    logic          o_EMPTY;
    logic          o_FULL;
    logic [LW-1:0] o_LEVEL;
    logic          o_OVF;
    logic          o_SHORT;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] exp;
    } vec_t;

    vec_t          vt [5];
    logic [31:0]   q [$];
    logic [15:0]   rw;
    logic [15:0]   lw;
    int            fall;

    always #5 clk = ~clk;

    ym_serial_capture #(.DEPTH(DEPTH), .LW(LW)) dut (
        .i_CLOCK     (clk),
        .i_RESET     (i_RESET),
        .i_DATA      (i_DATA),
        .i_LRCK      (i_LRCK),
        .i_ENABLE    (i_ENABLE),
        .i_RD        (i_RD),
        .i_CLR_FLAGS (i_CLR_FLAGS),
        .o_RDATA     (o_RDATA),
        .o_EMPTY     (o_EMPTY),
        .o_FULL      (o_FULL),
        .o_LEVEL     (o_LEVEL),
        .o_OVF       (o_OVF),
        .o_SHORT     (o_SHORT)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " empty"}, 32'(o_EMPTY), 32'd1);
        check({tag, " full"},  32'(o_FULL),  32'd0);
        check({tag, " level"}, 32'(o_LEVEL), 32'd0);
        check({tag, " ovf"},   32'(o_OVF),   32'd0);
        check({tag, " short"}, 32'(o_SHORT), 32'd0);
        check({tag, " rdata"}, o_RDATA,      32'd0);
    endtask

    // one LRCK half: MSB first, zero padding after 16 bits; i_RD pulsed on index rd_at
    task automatic drive_half(input logic lr, input logic [15:0] w, input int n, input int rd_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_LRCK = lr;
            i_DATA = (i < 16) ? w[15 - i] : 1'b0;
            i_RD   = (i == rd_at);
        end
        i_RD = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        drive_half(1'b1, l, 32, -1);
        drive_half(1'b0, r, 32, -1);
    endtask

    task automatic pop();
        @(negedge clk);
        i_RD = 1'b1;
        @(negedge clk);
        i_RD = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        i_CLR_FLAGS = 1'b1;
        @(negedge clk);
        i_CLR_FLAGS = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{16'h8000, 16'h7FC0, 32'h80007FC0};
        vt[1] = '{16'hFFFF, 16'h0000, 32'hFFFF0000};
        vt[2] = '{16'hA5A5, 16'h5A5A, 32'hA5A55A5A};
        vt[3] = '{16'h0001, 16'h8000, 32'h00018000};
        vt[4] = '{16'h1234, 16'hABCD, 32'h1234ABCD};

        repeat (3) @(negedge clk);
        check_reset("reset");
        i_RESET  = 1'b0;
        i_ENABLE = 1'b1;

        // LRCK low after reset starts a right word with no left partner: discarded
        drive_half(1'b0, 16'h0000, 20, -1);
        check("prime level", 32'(o_LEVEL), 32'd0);
        check("prime short", 32'(o_SHORT), 32'd0);

        // single frame with latency measured from the right-channel edge
        drive_half(1'b1, 16'h8000, 32, -1);
        rw   = 16'h7FC0;
        fall = -1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (fall < 0 && !o_EMPTY) fall = i;
            i_LRCK = 1'b0;
            i_DATA = (i < 16) ? rw[15 - i] : 1'b0;
        end
        check("single latency", fall, 32'd16);
        check("single rdata", o_RDATA, 32'h80007FC0);
        check("single level", 32'(o_LEVEL), 32'd1);
        check("single short", 32'(o_SHORT), 32'd0);
        pop();
        check("single empty", 32'(o_EMPTY), 32'd1);

        for (int v = 0; v < 5; v++) begin
            send_frame(vt[v].l, vt[v].r);
            check("vec rdata", o_RDATA, vt[v].exp);
            check("vec level", 32'(o_LEVEL), 32'd1);
            pop();
            check("vec empty", 32'(o_EMPTY), 32'd1);
        end

        // start mid-stream: enable rises during a right half
        i_ENABLE = 1'b0;
        drive_half(1'b1, 16'h5555, 32, -1);
        drive_half(1'b0, 16'h1234, 4, -1);
        i_ENABLE = 1'b1;
        drive_half(1'b0, 16'h1234, 28, -1);
        check("midstream partial level", 32'(o_LEVEL), 32'd0);
        send_frame(16'h0001, 16'hFFFF);
        check("midstream level", 32'(o_LEVEL), 32'd1);
        check("midstream rdata", o_RDATA, 32'h0001FFFF);
        check("midstream short", 32'(o_SHORT), 32'd0);
        pop();
        check("midstream empty", 32'(o_EMPTY), 32'd1);

        // short left word
        drive_half(1'b1, 16'hFFFF, 8, -1);
        drive_half(1'b0, 16'hAAAA, 32, -1);
        check("short flag", 32'(o_SHORT), 32'd1);
        check("short level", 32'(o_LEVEL), 32'd0);
        send_frame(16'h1357, 16'h2468);
        check("short next level", 32'(o_LEVEL), 32'd1);
        check("short next rdata", o_RDATA, 32'h13572468);
        pulse_clr();
        check("short cleared", 32'(o_SHORT), 32'd0);
        pop();

        // aborted right word drops the held left word
        drive_half(1'b1, 16'h0F0F, 32, -1);
        drive_half(1'b0, 16'h1111, 8, -1);
        drive_half(1'b1, 16'h2222, 8, -1);
        drive_half(1'b0, 16'h3333, 32, -1);
        check("abort right level", 32'(o_LEVEL), 32'd0);
        check("abort right short", 32'(o_SHORT), 32'd1);
        pulse_clr();
        check("abort right cleared", 32'(o_SHORT), 32'd0);

        // short event in the same cycle as a clear: set wins
        drive_half(1'b1, 16'h4444, 8, -1);
        @(negedge clk);
        i_LRCK      = 1'b0;
        i_DATA      = 1'b0;
        i_CLR_FLAGS = 1'b1;
        @(negedge clk);
        i_CLR_FLAGS = 1'b0;
        drive_half(1'b0, 16'h0000, 30, -1);
        check("set wins short", 32'(o_SHORT), 32'd1);
        pulse_clr();
        check("set wins cleared", 32'(o_SHORT), 32'd0);

        // overflow
        for (int k = 0; k <= DEPTH; k++) begin
            send_frame(16'(k), 16'(k));
        end
        check("ovf full", 32'(o_FULL), 32'd1);
        check("ovf level", 32'(o_LEVEL), 32'd16);
        check("ovf flag", 32'(o_OVF), 32'd1);
        check("ovf head", o_RDATA, 32'h00000000);
        pulse_clr();
        check("ovf cleared", 32'(o_OVF), 32'd0);
        drive_half(1'b1, 16'd99, 32, -1);
        drive_half(1'b0, 16'd99, 32, 15);
        check("full push+pop ovf", 32'(o_OVF), 32'd0);
        check("full push+pop level", 32'(o_LEVEL), 32'd16);
        check("full push+pop full", 32'(o_FULL), 32'd1);
        for (int k = 1; k < DEPTH; k++) begin
            check("ovf drain data", o_RDATA, {16'(k), 16'(k)});
            check("ovf drain level", 32'(o_LEVEL), 32'(17 - k));
            pop();
        end
        check("ovf drain last", o_RDATA, 32'h00630063);
        pop();
        check("ovf drain empty", 32'(o_EMPTY), 32'd1);
        check("ovf drain full", 32'(o_FULL), 32'd0);

        // wrap-around with interleaved pops
        q.delete();
        for (int k = 0; k < 40; k++) begin
            lw = 16'h0100 + 16'(k);
            rw = 16'hF000 ^ 16'(k);
            send_frame(lw, rw);
            q.push_back({lw, rw});
            check("wrap push level", 32'(o_LEVEL), q.size());
            if (k % 4 == 3) begin
                for (int p = 0; p < 3; p++) begin
                    check("wrap data", o_RDATA, q[0]);
                    void'(q.pop_front());
                    pop();
                    check("wrap pop level", 32'(o_LEVEL), q.size());
                end
            end
        end
        for (int p = 0; p < DEPTH && q.size() > 0; p++) begin
            check("wrap drain data", o_RDATA, q[0]);
            void'(q.pop_front());
            pop();
            check("wrap drain level", 32'(o_LEVEL), q.size());
        end
        check("wrap empty", 32'(o_EMPTY), 32'd1);

        // reset on bit 7 of a left word with 3 frames queued
        send_frame(16'hA1A1, 16'hB1B1);
        send_frame(16'hA2A2, 16'hB2B2);
        send_frame(16'hA3A3, 16'hB3B3);
        check("pre-reset level", 32'(o_LEVEL), 32'd3);
        drive_half(1'b1, 16'hFFFF, 7, -1);
        @(negedge clk);
        i_DATA  = 1'b1;
        i_RESET = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset("midword reset");
        i_RESET = 1'b0;
        drive_half(1'b0, 16'h7777, 32, -1);
        check("post-reset stray level", 32'(o_LEVEL), 32'd0);
        send_frame(16'hCAFE, 16'hBEEF);
        check("post-reset level", 32'(o_LEVEL), 32'd1);
        check("post-reset rdata", o_RDATA, 32'hCAFEBEEF);
        pop();
        check("post-reset empty", 32'(o_EMPTY), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
